// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction-fetch unit feeding the IF/ID pipeline register.
//
// Owns the program counter. Issues one outstanding request at a time to the
// instruction memory over a req/ready handshake. Holds a fetched instruction
// while the pipeline is frozen. Accepts branch redirects from ID.
//
// Parameters
//   RESET_PC      PC fetched first after reset (low two bits ignored)
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_i         synchronous active-high reset
//   Stall_i       load-use stall from the hazard unit
//   MemStall_i    data-memory stall; freezes everything, masks Flush_i
//   Flush_i       branch taken in ID; redirect to BranchAddr_i
//   BranchAddr_i  redirect target (forced word-aligned)
//   imem_req_o    fetch request
//   imem_addr_o   fetch address, stable from request until ready
//   imem_ready_i  one-cycle response pulse for the outstanding request
//   imem_rdata_i  instruction word, valid with imem_ready_i
//   PC_o          PC of the presented instruction
//   instr_o       presented instruction
//   valid_o       PC_o/instr_o valid this cycle
// -----------------------------------------------------------------------------
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        Stall_i,
   input  logic        MemStall_i,
   input  logic        Flush_i,
   input  logic [31:0] BranchAddr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] PC_o,
   output logic [31:0] instr_o,
   output logic        valid_o
);

   localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

   // FETCH: request outstanding, response is live.
   // HOLD : response captured, waiting for IF/ID to accept; no request.
   // DROP : request outstanding but its response belongs to a squashed path.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DROP  = 2'd2
   } state_e;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
   } imem_req_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_rsp_t;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;

   imem_req_t   ireq;
   fetch_rsp_t  pres;

   logic        adv;
   logic        redir;
   logic [31:0] br_addr;

   assign adv     = ~Stall_i & ~MemStall_i;
   // A frozen pipeline cannot act on a branch; the flush is re-presented by
   // ID once MemStall_i drops.
   assign redir   = Flush_i & ~MemStall_i;
   assign br_addr = {BranchAddr_i[31:2], 2'b00};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;
      ireq         = '0;
      pres         = '0;

      unique case (state_q)
         S_FETCH: begin
            ireq.req  = 1'b1;
            ireq.addr = pc_q;
            if (imem_ready_i) begin
               // Cache hit path: data flows straight through to IF/ID.
               pres.valid = 1'b1;
               pres.pc    = pc_q;
               pres.instr = imem_rdata_i;
            end
            if (redir) begin
               if (imem_ready_i) begin
                  pc_d = br_addr;
               end else begin
                  // Address must stay stable until ready, so park the target
                  // and squash the response when it arrives.
                  tgt_d   = br_addr;
                  state_d = S_DROP;
               end
            end else if (imem_ready_i) begin
               if (adv) begin
                  pc_d = pc_q + 32'd4;
               end else begin
                  hold_pc_d    = pc_q;
                  hold_instr_d = imem_rdata_i;
                  state_d      = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            // No request here, so imem_ready_i is don't-care.
            ireq.addr  = pc_q;
            pres.valid = 1'b1;
            pres.pc    = hold_pc_q;
            pres.instr = hold_instr_q;
            if (redir) begin
               pc_d    = br_addr;
               state_d = S_FETCH;
            end else if (adv) begin
               pc_d    = hold_pc_q + 32'd4;
               state_d = S_FETCH;
            end
         end

         S_DROP: begin
            ireq.req  = 1'b1;
            ireq.addr = pc_q;
            if (redir) tgt_d = br_addr;
            if (imem_ready_i) begin
               // Latest redirect wins, including one arriving with ready.
               pc_d    = redir ? br_addr : tgt_q;
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC_A;
         tgt_q        <= '0;
         hold_pc_q    <= '0;
         hold_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         tgt_q        <= tgt_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   // Outputs are combinational (same-cycle pass-through of imem data), and are
   // forced quiet while reset is held so no request escapes before the first
   // post-reset cycle.
   assign imem_req_o  = ireq.req & ~rst_i;
   assign imem_addr_o = rst_i ? 32'd0 : ireq.addr;
   assign valid_o     = pres.valid & ~rst_i;
   assign PC_o        = rst_i ? 32'd0 : pres.pc;
   assign instr_o     = rst_i ? 32'd0 : pres.instr;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst, stall, mstall, flush;
   logic [31:0] ba;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_o, instr_o;
   logic        valid_o;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk), .rst_i(rst), .Stall_i(stall), .MemStall_i(mstall),
      .Flush_i(flush), .BranchAddr_i(ba),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata),
      .PC_o(pc_o), .instr_o(instr_o), .valid_o(valid_o)
   );

   // ---------------- memory model ----------------
   int          lat = 0;     // cycles from request to ready
   int          cnt;
   logic        spur = 1'b0; // extra ready pulse, regardless of request
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_val = '0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1357_0013;
   endfunction

   assign imem_rdata = ovr_en ? ovr_val : mem(imem_addr);
   assign imem_ready = (imem_req && (cnt >= lat)) || spur;

   always_ff @(posedge clk) begin
      if (rst || !imem_req || imem_ready) cnt <= 0;
      else                                cnt <= cnt + 1;
   end

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%h exp=%h @%0t", n, a, e, $time);
      end
   endtask

   // Literal expectations posted by the stimulus for the current cycle.
   string       lname = "";
   bit          le_req, le_addr, le_val, le_pc, le_ins;
   logic        lv_req, lv_val;
   logic [31:0] lv_addr, lv_pc, lv_ins;

   // Fetch-model state: address of the next/outstanding fetch, whether the
   // outstanding response is squashed, and any instruction parked for IF/ID.
   logic [31:0] m_pc = '0, m_tgt = '0, m_hpc = '0, m_hins = '0;
   bit          m_held = 0, m_drop = 0;

   always @(negedge clk) begin : cmp
      bit          e_req, e_val, rdy, br, take;
      logic [31:0] e_pc, e_ins, dat, bt;

      if (le_req)  chk({lname, ":req"},   {31'd0, imem_req}, {31'd0, lv_req});
      if (le_addr) chk({lname, ":addr"},  imem_addr, lv_addr);
      if (le_val)  chk({lname, ":valid"}, {31'd0, valid_o}, {31'd0, lv_val});
      if (le_pc)   chk({lname, ":pc"},    pc_o, lv_pc);
      if (le_ins)  chk({lname, ":instr"}, instr_o, lv_ins);

      dat  = ovr_en ? ovr_val : mem(m_pc);
      rdy  = imem_ready;
      br   = flush && !mstall;
      take = !stall && !mstall;
      bt   = {ba[31:2], 2'b00};

      if (rst) begin
         chk("m:rst_req",   {31'd0, imem_req}, 32'd0);
         chk("m:rst_valid", {31'd0, valid_o},  32'd0);
         chk("m:rst_pc",    pc_o,    32'd0);
         chk("m:rst_instr", instr_o, 32'd0);
         m_pc = 32'h0; m_tgt = '0; m_hpc = '0; m_hins = '0;
         m_held = 0; m_drop = 0;
      end else begin
         e_req = !m_held;
         e_val = m_held || (rdy && !m_drop);
         e_pc  = m_held ? m_hpc  : m_pc;
         e_ins = m_held ? m_hins : dat;
         chk("m:req",   {31'd0, imem_req}, {31'd0, e_req});
         chk("m:valid", {31'd0, valid_o},  {31'd0, e_val});
         if (e_req) chk("m:addr", imem_addr, m_pc);
         if (e_val) begin
            chk("m:pc",    pc_o,    e_pc);
            chk("m:instr", instr_o, e_ins);
         end
         // What happens next, from the fetch rules.
         if (m_held) begin
            if (br)        begin m_held = 0; m_pc = bt; end
            else if (take) begin m_held = 0; m_pc = m_hpc + 32'd4; end
         end else if (m_drop) begin
            if (br) m_tgt = bt;
            if (rdy) begin m_drop = 0; m_pc = m_tgt; end
         end else if (br) begin
            if (rdy) m_pc = bt;
            else begin m_drop = 1; m_tgt = bt; end
         end else if (rdy) begin
            if (take) m_pc = m_pc + 32'd4;
            else begin m_held = 1; m_hpc = m_pc; m_hins = dat; end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
      le_req = 0; le_addr = 0; le_val = 0; le_pc = 0; le_ins = 0;
   endtask

   task automatic x_req(input string n, input logic r);
      lname = n; le_req = 1; lv_req = r;
   endtask
   task automatic x_addr(input string n, input logic [31:0] a);
      lname = n; le_addr = 1; lv_addr = a;
   endtask
   task automatic x_val(input string n, input logic v);
      lname = n; le_val = 1; lv_val = v;
   endtask
   task automatic x_pc(input string n, input logic [31:0] p);
      lname = n; le_pc = 1; lv_pc = p;
   endtask
   task automatic x_ins(input string n, input logic [31:0] i);
      lname = n; le_ins = 1; lv_ins = i;
   endtask

   task automatic do_rst();
      tick();
      rst = 1; stall = 0; mstall = 0; flush = 0; ba = '0;
      lat = 0; spur = 0; ovr_en = 0;
   endtask

   initial begin
      le_req = 0; le_addr = 0; le_val = 0; le_pc = 0; le_ins = 0;
      lv_req = 0; lv_val = 0; lv_addr = '0; lv_pc = '0; lv_ins = '0;
      rst = 1; stall = 0; mstall = 0; flush = 0; ba = '0;

      // reset outputs
      tick();
      x_req("rst", 0); x_val("rst", 0); x_pc("rst", 0); x_ins("rst", 0);

      // streaming, same-cycle ready
      tick(); rst = 0;
      x_addr("s0", 32'h0); x_val("s0", 1); x_pc("s0", 32'h0); x_ins("s0", 32'h1357_0013);
      tick(); x_addr("s1", 32'h4); x_val("s1", 1); x_pc("s1", 32'h4); x_ins("s1", 32'h1357_0017);
      tick(); x_addr("s2", 32'h8); x_val("s2", 1); x_pc("s2", 32'h8);
      tick(); x_addr("s3", 32'hC); x_val("s3", 1); x_pc("s3", 32'hC);

      // slow memory: ready two cycles after request
      do_rst();
      tick(); rst = 0; lat = 2; x_addr("w0", 32'h0); x_val("w0", 0);
      tick(); x_addr("w1", 32'h0); x_val("w1", 0);
      tick(); x_addr("w2", 32'h0); x_val("w2", 1); x_pc("w2", 32'h0);
      tick(); x_addr("w3", 32'h4); x_val("w3", 0);

      // stall with ready: hold, ignore stray ready, then resume
      do_rst();
      tick(); rst = 0; ovr_en = 1; ovr_val = 32'h0050_0093; stall = 1;
      x_req("h0", 1); x_val("h0", 1); x_ins("h0", 32'h0050_0093);
      tick(); ovr_en = 0; spur = 1;
      x_req("h1", 0); x_val("h1", 1); x_pc("h1", 32'h0); x_ins("h1", 32'h0050_0093);
      tick(); stall = 0; spur = 0;
      x_req("h2", 0); x_val("h2", 1); x_ins("h2", 32'h0050_0093);
      tick(); x_req("h3", 1); x_addr("h3", 32'h4); x_val("h3", 1); x_pc("h3", 32'h4);

      // flush while request at 8 pending; second flush overrides, low bits dropped
      do_rst();
      tick(); rst = 0; x_addr("d0", 32'h0);
      tick(); x_addr("d1", 32'h4);
      tick(); lat = 2; flush = 1; ba = 32'h80; x_addr("d2", 32'h8); x_val("d2", 0);
      tick(); ba = 32'h43; x_addr("d3", 32'h8); x_val("d3", 0);
      tick(); flush = 0; x_addr("d4", 32'h8); x_val("d4", 0);
      tick(); lat = 0; x_addr("d5", 32'h40); x_val("d5", 1); x_pc("d5", 32'h40);

      // flush masked by MemStall, applied when it drops
      do_rst();
      tick(); rst = 0; mstall = 1; flush = 1; ba = 32'h100;
      x_val("m0", 1); x_pc("m0", 32'h0);
      tick(); x_req("m1", 0); x_val("m1", 1); x_pc("m1", 32'h0);
      tick(); mstall = 0; x_val("m2", 1);
      tick(); flush = 0; x_addr("m3", 32'h100); x_val("m3", 1); x_pc("m3", 32'h100);

      // PC wrap, then reset during a wait
      do_rst();
      tick(); rst = 0; flush = 1; ba = 32'hFFFF_FFFC; x_addr("p0", 32'h0);
      tick(); flush = 0; x_addr("p1", 32'hFFFF_FFFC); x_val("p1", 1); x_pc("p1", 32'hFFFF_FFFC);
      tick(); lat = 3; x_addr("p2", 32'h0); x_val("p2", 0);
      tick(); rst = 1; x_req("p3", 0); x_val("p3", 0); x_pc("p3", 0); x_ins("p3", 0);
      tick(); rst = 0; lat = 0; x_addr("p4", 32'h0); x_val("p4", 1); x_pc("p4", 32'h0);

      // stall and flush together: flush wins
      do_rst();
      tick(); rst = 0; stall = 1; flush = 1; ba = 32'h200; x_val("f0", 1); x_pc("f0", 32'h0);
      tick(); flush = 0; x_req("f1", 1); x_addr("f1", 32'h200); x_pc("f1", 32'h200);

      // mixed traffic, checked by the model only
      do_rst();
      tick(); rst = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         stall  = ($urandom_range(0, 3) == 0);
         mstall = ($urandom_range(0, 4) == 0);
         flush  = ($urandom_range(0, 5) == 0);
         ba     = $urandom;
         lat    = $urandom_range(0, 2);
         spur   = ($urandom_range(0, 9) == 0);
         rst    = ($urandom_range(0, 39) == 0);
      end

      do_rst();
      tick(); rst = 0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
